// File: rtl/packet_dispatcher.sv
// packet_dispatcher: steers packets from one input stream onto one of OUT_NUM lanes through a single output register.
// Define PKT_DISPATCH_STATS_EN to add saturating forwarded/dropped packet counters.
module packet_dispatcher #(
  parameter int OUT_NUM = 8,
  parameter int DATA_W  = 1,
  parameter int DEST_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      last_in,
  input  logic [DEST_W-1:0]         dest_in,
  output logic                      ready_in,
  output logic [OUT_NUM-1:0]        valid_out,
  output logic [OUT_NUM*DATA_W-1:0] data_out,
  output logic [OUT_NUM-1:0]        last_out,
  input  logic [OUT_NUM-1:0]        ready_out
`ifdef PKT_DISPATCH_STATS_EN
  ,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e              state_q, state_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [DEST_W-1:0]   sel_q, sel_d;
  logic [DEST_W-1:0]   pkt_sel_q, pkt_sel_d;

  logic drainReady;
  logic inFire;
  logic outFire;
  logic destOk;
  logic load;

  always_comb begin
    drainReady = 1'b0;
    for (int k = 0; k < OUT_NUM; k++) begin
      if (sel_q == DEST_W'(k)) drainReady = ready_out[k];
    end
  end

  assign inFire  = valid_in && ready_in;
  assign outFire = vld_q && drainReady;
  assign destOk  = 32'(dest_in) < OUT_NUM;
  // Dropped beats never touch the output register; only routable first beats and FWD beats load it.
  assign load    = inFire && (((state_q == IDLE) && destOk) || (state_q == FWD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inFire && !last_in) state_d = destOk ? FWD : DROP;
      FWD:     if (inFire && last_in)  state_d = IDLE;
      DROP:    if (inFire && last_in)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_in  = 1'b0;
    valid_out = '0;
    data_out  = '0;
    last_out  = '0;
    if (!rst) ready_in = (state_q == DROP) ? 1'b1 : (!vld_q || drainReady);
    for (int k = 0; k < OUT_NUM; k++) begin
      if (vld_q && (sel_q == DEST_W'(k))) begin
        valid_out[k]                 = 1'b1;
        data_out[k*DATA_W +: DATA_W] = data_q;
        last_out[k]                  = last_q;
      end
    end
  end

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    last_d    = last_q;
    sel_d     = sel_q;
    pkt_sel_d = pkt_sel_q;
    if (outFire) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      data_d = data_in;
      last_d = last_in;
      sel_d  = (state_q == IDLE) ? dest_in : pkt_sel_q;
    end
    if ((state_q == IDLE) && inFire && destOk) pkt_sel_d = dest_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      sel_q     <= '0;
      pkt_sel_q <= '0;
    end else begin
      vld_q     <= vld_d;
      data_q    <= data_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      pkt_sel_q <= pkt_sel_d;
    end
  end

`ifdef PKT_DISPATCH_STATS_EN
  logic dropLast;

  assign dropLast = inFire && last_in && (((state_q == IDLE) && !destOk) || (state_q == DROP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (outFire && last_q && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
      if (dropLast && (drop_cnt != 16'hFFFF))         drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_dispatcher.sv
// tb_packet_dispatcher: directed scenarios checked against a packet-level queue model of the dispatcher.
// Uses OUT_NUM=6 so destinations 6 and 7 exercise the drop path; counters are checked when PKT_DISPATCH_STATS_EN is defined.
module tb_packet_dispatcher;

   localparam int OUT_NUM = 6;
   localparam int DATA_W  = 8;
   localparam int DEST_W  = 3;

   logic                      clk;
   logic                      rst;
   logic                      valid_in;
   logic [DATA_W-1:0]         data_in;
   logic                      last_in;
   logic [DEST_W-1:0]         dest_in;
   logic                      ready_in;
   logic [OUT_NUM-1:0]        valid_out;
   logic [OUT_NUM*DATA_W-1:0] data_out;
   logic [OUT_NUM-1:0]        last_out;
   logic [OUT_NUM-1:0]        ready_out;
`ifdef PKT_DISPATCH_STATS_EN
   logic [15:0]               pkt_cnt;
   logic [15:0]               drop_cnt;
`endif

   packet_dispatcher #(
      .OUT_NUM(OUT_NUM),
      .DATA_W (DATA_W),
      .DEST_W (DEST_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .data_in  (data_in),
      .last_in  (last_in),
      .dest_in  (dest_in),
      .ready_in (ready_in),
      .valid_out(valid_out),
      .data_out (data_out),
      .last_out (last_out),
      .ready_out(ready_out)
`ifdef PKT_DISPATCH_STATS_EN
      ,
      .pkt_cnt  (pkt_cnt),
      .drop_cnt (drop_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int               lane;
      logic [DATA_W-1:0] data;
      logic             last;
   } beat_t;

   beat_t expQ[$];
   bit    inPkt;
   bit    pktDrop;
   int    curDest;
   int    expPkt;
   int    expDrop;
   int    checkCount = 0;
   int    passCount  = 0;

   // Every comparison in the bench funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Drives one input beat; timing is handled by the caller.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic [DEST_W-1:0] dst);
      valid_in = v;
      data_in  = d;
      last_in  = l;
      dest_in  = dst;
   endtask

   // Waits until the currently driven beat is accepted, returning the number of stalled cycles.
   task automatic waitAccept(output int waited);
      bit ok;
      ok     = 1'b0;
      waited = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (ready_in === 1'b1) ok = 1'b1;
         else begin
            @(posedge clk);
            #2;
            waited++;
         end
      end
      if (!ok) begin
         checkCount++;
         $display("[TB] FAIL accept_timeout: ready_in stayed %b, required 1", ready_in);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic sendBeat(input logic [DATA_W-1:0] d, input logic l, input logic [DEST_W-1:0] dst, output int waited);
      applyStimulus(1'b1, d, l, dst);
      waitAccept(waited);
   endtask

   task automatic idleCycles(input int n);
      applyStimulus(1'b0, '0, 1'b0, '0);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Packet-level model: a FIFO of beats owed to the lanes plus the routing decision for the current packet.
   // Each falling edge compares the DUT against the model, then advances the model by the coming rising edge.
   initial begin
      logic [OUT_NUM-1:0]        eValid;
      logic [OUT_NUM-1:0]        eLast;
      logic [OUT_NUM*DATA_W-1:0] eData;
      logic                      eReady;
      bit                        outFire;
      bit                        inFire;
      beat_t                     nb;
      forever begin
         @(negedge clk);
         if (rst) begin
            expQ.delete();
            inPkt   = 1'b0;
            pktDrop = 1'b0;
            expPkt  = 0;
            expDrop = 0;
         end
         eValid = '0;
         eLast  = '0;
         eData  = '0;
         if (expQ.size() > 0) begin
            eValid[expQ[0].lane]             = 1'b1;
            eLast[expQ[0].lane]              = expQ[0].last;
            eData[expQ[0].lane*DATA_W +: DATA_W] = expQ[0].data;
         end
         if (rst)                 eReady = 1'b0;
         else if (inPkt && pktDrop) eReady = 1'b1;
         else                     eReady = (expQ.size() == 0) || (ready_out[expQ[0].lane] === 1'b1);

         checkOutput("model_ready_in",  64'(ready_in),  64'(eReady));
         checkOutput("model_valid_out", 64'(valid_out), 64'(eValid));
         checkOutput("model_data_out",  64'(data_out),  64'(eData));
         checkOutput("model_last_out",  64'(last_out),  64'(eLast));
`ifdef PKT_DISPATCH_STATS_EN
         checkOutput("model_pkt_cnt",   64'(pkt_cnt),   64'(expPkt));
         checkOutput("model_drop_cnt",  64'(drop_cnt),  64'(expDrop));
`endif

         outFire = (expQ.size() > 0) && (ready_out[expQ[0].lane] === 1'b1) && !rst;
         inFire  = (valid_in === 1'b1) && eReady;
         if (outFire) begin
            if (expQ[0].last && expPkt < 65535) expPkt++;
            void'(expQ.pop_front());
         end
         if (inFire) begin
            if (!inPkt) begin
               if (int'(dest_in) < OUT_NUM) begin
                  curDest = int'(dest_in);
                  pktDrop = 1'b0;
               end else begin
                  pktDrop = 1'b1;
               end
            end
            if (pktDrop) begin
               if (last_in && expDrop < 65535) expDrop++;
            end else begin
               nb.lane = curDest;
               nb.data = data_in;
               nb.last = last_in;
               expQ.push_back(nb);
            end
            inPkt = !last_in;
         end
      end
   end

   // Directed scenarios with hand-computed expectations on top of the model.
   initial begin
      int w;
      rst       = 1'b1;
      ready_out = '1;
      applyStimulus(1'b0, '0, 1'b0, '0);
      #3;
      checkOutput("reset_valid_out", 64'(valid_out), 64'd0);
      checkOutput("reset_data_out",  64'(data_out),  64'd0);
      checkOutput("reset_last_out",  64'(last_out),  64'd0);
      checkOutput("reset_ready_in",  64'(ready_in),  64'd0);
`ifdef PKT_DISPATCH_STATS_EN
      checkOutput("reset_pkt_cnt",   64'(pkt_cnt),   64'd0);
      checkOutput("reset_drop_cnt",  64'(drop_cnt),  64'd0);
`endif
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;

      $display("[TB] scenario 1: 8-beat packet to lane 3");
      for (int b = 1; b <= 8; b++) begin
         sendBeat(8'(8'h10 + b), (b == 8), 3'd3, w);
         checkOutput("s1_no_stall", 64'(w), 64'd0);
         checkOutput("s1_valid",    64'(valid_out), 64'b001000);
         checkOutput("s1_last3",    64'(last_out[3]), 64'(b == 8));
         checkOutput("s1_data3",    64'(data_out[3*DATA_W +: DATA_W]), 64'(8'h10 + b));
      end
      idleCycles(1);
      checkOutput("s1_drained", 64'(valid_out), 64'd0);
      idleCycles(1);

      $display("[TB] scenario 2: dest changes mid-packet are ignored");
      for (int b = 1; b <= 4; b++) begin
         sendBeat(8'(8'h20 + b), (b == 4), (b == 1) ? 3'd2 : 3'd5, w);
         checkOutput("s2_valid_lane2", 64'(valid_out), 64'b000100);
         checkOutput("s2_data2",       64'(data_out[2*DATA_W +: DATA_W]), 64'(8'h20 + b));
      end
      idleCycles(2);

      $display("[TB] scenario 3: lane 1 back-pressure mid-packet");
      sendBeat(8'h31, 1'b0, 3'd1, w);
      sendBeat(8'h32, 1'b0, 3'd1, w);
      ready_out = 6'b111101;
      applyStimulus(1'b1, 8'h33, 1'b0, 3'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("s3_ready_low", 64'(ready_in), 64'd0);
         checkOutput("s3_hold_data", 64'(data_out[1*DATA_W +: DATA_W]), 64'h32);
         checkOutput("s3_hold_vld",  64'(valid_out), 64'b000010);
         @(posedge clk);
         #2;
      end
      ready_out = '1;
      waitAccept(w);
      checkOutput("s3_resume_no_stall", 64'(w), 64'd0);
      checkOutput("s3_beat3", 64'(data_out[1*DATA_W +: DATA_W]), 64'h33);
      for (int b = 4; b <= 6; b++) begin
         sendBeat(8'(8'h30 + b), (b == 6), 3'd1, w);
         checkOutput("s3_beat", 64'(data_out[1*DATA_W +: DATA_W]), 64'(8'h30 + b));
      end
      idleCycles(2);

      $display("[TB] scenario 4: packet to unmapped dest 7 is dropped");
      for (int b = 1; b <= 3; b++) begin
         sendBeat(8'(8'h40 + b), (b == 3), (b == 1) ? 3'd7 : 3'(b), w);
         checkOutput("s4_ready_high", 64'(w), 64'd0);
         checkOutput("s4_no_valid",   64'(valid_out), 64'd0);
      end
`ifdef PKT_DISPATCH_STATS_EN
      checkOutput("s4_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
      idleCycles(2);

      $display("[TB] scenario 5: back-to-back single-beat packets");
      sendBeat(8'h51, 1'b1, 3'd0, w);
      checkOutput("s5_lane0", 64'(valid_out), 64'b000001);
      sendBeat(8'h52, 1'b1, 3'd4, w);
      checkOutput("s5_no_idle", 64'(w), 64'd0);
      checkOutput("s5_lane4",   64'(valid_out), 64'b010000);
      checkOutput("s5_data4",   64'(data_out[4*DATA_W +: DATA_W]), 64'h52);
      idleCycles(2);
`ifdef PKT_DISPATCH_STATS_EN
      checkOutput("s5_pkt_cnt", 64'(pkt_cnt), 64'd5);
`endif

      $display("[TB] scenario 6: reset during beat 3");
      sendBeat(8'h61, 1'b0, 3'd2, w);
      sendBeat(8'h62, 1'b0, 3'd2, w);
      applyStimulus(1'b1, 8'h63, 1'b0, 3'd2);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("s6_rst_valid", 64'(valid_out), 64'd0);
      checkOutput("s6_rst_data",  64'(data_out),  64'd0);
      checkOutput("s6_rst_last",  64'(last_out),  64'd0);
      checkOutput("s6_rst_ready", 64'(ready_in),  64'd0);
      @(posedge clk);
      #2;
      applyStimulus(1'b0, '0, 1'b0, '0);
      rst = 1'b0;
      sendBeat(8'h71, 1'b0, 3'd5, w);
      checkOutput("s6_new_lane5", 64'(valid_out), 64'b100000);
      sendBeat(8'h72, 1'b1, 3'd5, w);
      checkOutput("s6_new_last5", 64'(last_out), 64'b100000);
      checkOutput("s6_new_data5", 64'(data_out[5*DATA_W +: DATA_W]), 64'h72);
      idleCycles(3);
`ifdef PKT_DISPATCH_STATS_EN
      checkOutput("s6_pkt_cnt",  64'(pkt_cnt),  64'd1);
      checkOutput("s6_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/packet_dispatcher.md
PACKET_DISPATCHER -- requirements
Module: packet_dispatcher

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- OUT_NUM, 8, number of output streams (2..16)
- DATA_W, 1, beat data width
- DEST_W, 3, destination field width; must be at least clog2(OUT_NUM)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- valid_in  input  1  input beat valid
- data_in  input  DATA_W  input beat data
- last_in  input  1  final beat of packet
- dest_in  input  DEST_W  destination index; sampled on first beat only
- ready_in  output  1  dispatcher accepts beat
- valid_out  output  OUT_NUM  per-output beat valid; at most one bit set
- data_out  output  OUT_NUM*DATA_W  per-output data; lane k at bits [k*DATA_W +: DATA_W]
- last_out  output  OUT_NUM  per-output final-beat flag
- ready_out  input  OUT_NUM  per-output downstream ready
- pkt_cnt  output  16  completed forwarded packets (present only with PKT_DISPATCH_STATS_EN)
- drop_cnt  output  16  dropped packets (present only with PKT_DISPATCH_STATS_EN)

Function
REQ-003 Input fire SHALL be valid_in && ready_in; output fire on lane k SHALL be valid_out[k] && ready_out[k].
REQ-004 Block SHALL contain a single output register (vld, data, last, sel); latency from input fire to valid_out SHALL be exactly 1 cycle.
REQ-005 valid_out[k] SHALL equal vld && (sel == k); data_out and last_out on lanes other than sel SHALL be zero.
REQ-006 FSM SHALL have states IDLE, FWD, DROP; IDLE means the next accepted beat is a packet's first beat.
REQ-007 In IDLE or FWD, ready_in SHALL be !vld || ready_out[sel] (full throughput: accept and drain in the same cycle).
REQ-008 In DROP, ready_in SHALL be 1 and accepted beats SHALL NOT load the output register.
REQ-009 IDLE, first-beat fire with dest_in < OUT_NUM: load register with sel = dest_in and latch pkt_sel = dest_in; next state IDLE if last_in, else FWD.
REQ-010 IDLE, first-beat fire with dest_in >= OUT_NUM: beat discarded; next state IDLE if last_in, else DROP.
REQ-011 FWD: each fire loads register with sel = latched pkt_sel; dest_in ignored; on a last_in fire return to IDLE.
REQ-012 DROP: on a last_in fire return to IDLE.
REQ-013 Output register SHALL clear vld on an output fire not accompanied by a new load; a simultaneous drain and load SHALL leave vld = 1 with the new beat.
REQ-014 Beats of one packet SHALL never interleave with another packet on any lane; beat order SHALL be preserved.
REQ-015 A held beat (vld = 1, ready_out[sel] = 0) SHALL keep data_out, last_out and sel stable until it fires.

Reset
REQ-016 While rst = 1: FSM = IDLE, vld = 0, sel = 0, pkt_sel = 0, valid_out = 0, data_out = 0, last_out = 0, and counters = 0.
REQ-017 ready_in SHALL be 0 while rst = 1.
REQ-018 Reset asserted mid-packet SHALL discard the held beat and partial packet; the first beat accepted after release SHALL be treated as a new packet's first beat.

Configuration
REQ-019 Macro PKT_DISPATCH_STATS_EN defined: pkt_cnt SHALL increment on every output fire with last_out set, and drop_cnt SHALL increment on every discarded last_in fire (REQ-010 with last_in, or REQ-012); both SHALL saturate at 16'hFFFF.
REQ-020 Macro PKT_DISPATCH_STATS_EN undefined: pkt_cnt, drop_cnt and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- 8-beat packet to dest 3, ready_out all 1 -> valid_out = 8'b0000_1000 for 8 consecutive cycles starting 1 cycle after the first fire; last_out[3] on beat 8 only.
- Packet to dest 2 with dest_in changed to 5 on beats 2..4 -> all beats on lane 2; lane 5 never valid.
- ready_out[1] = 0 for 4 cycles mid-packet -> ready_in = 0 from the next cycle; data_out lane 1 stable; no beat lost or duplicated.
- OUT_NUM = 6, 3-beat packet with dest 7 -> ready_in = 1 throughout, valid_out stays 0, drop_cnt = 1 when enabled.
- Back-to-back single-beat packets to dest 0 then dest 4 -> lane 4 valid the cycle after lane 0 fires; no idle cycle.
- rst pulsed during beat 3 of 8 -> all outputs 0 immediately; next packet after release routed by its own dest_in.
